// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, D = A - B.
// One full-subtractor cell with a registered borrow processes one bit per
// clock, LSB first, over WIDTH cycles. Operands enter and results leave
// through valid/ready handshakes.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the OVF output
// (signed two's-complement overflow of A - B).
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready are both high. The consumer may hold out_ready low
// for as long as it likes; D/BORROW (and OVF) stay frozen while out_valid=1.
// in_valid outside IDLE and out_ready outside DONE are ignored.
//
// state_dbg exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for observation.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             BORROW,
    output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
    output logic             OVF,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    state_t          next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]   cnt;
    logic            br;
    logic            borrow_q;
    logic            accept;
    logic            last_bit;
    logic            a_bit;
    logic            b_bit;
    logic            d_bit;
    logic            br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic            a_msb;
    logic            b_msb;
    logic            ovf_q;
`endif

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last_bit   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Full-subtractor cell working on the current LSBs.
    always_comb begin
        a_bit   = a_sh[0];
        b_bit   = b_sh[0];
        d_bit   = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    // Operand/result shift registers, borrow flop and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_reg    <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_sh  <= A;
                b_sh  <= B;
                d_reg <= '0;
                cnt   <= '0;
                br    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
                ovf_q <= 1'b0;
`endif
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                d_reg <= {d_bit, d_reg[WIDTH-1:1]};
                cnt   <= cnt + CW'(1);
                br    <= br_next;
                if (last_bit) begin
                    borrow_q <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // d_bit is the result MSB on the final RUN edge.
                    ovf_q <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                end
            end
        end
    end

    assign D         = d_reg;
    assign BORROW    = borrow_q;
    assign state_dbg = state;
`ifdef SERIAL_SUB_OVF_EN
    assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed, table-driven bench for serial_subtractor
// (WIDTH=4), plus hand-written backpressure, reset-abort and back-to-back
// sequences. OVF is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             BORROW;
    logic             busy;
    logic [1:0]       state_dbg;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_d;
        logic             exp_borrow;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[11];
    logic [WIDTH:0] exp_q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .BORROW    (BORROW),
        .busy      (busy),
`ifdef SERIAL_SUB_OVF_EN
        .OVF       (ovf),
`endif
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: one full operation with out_ready held high. Returns the
    // result, the latency in cycles from the accepting edge to out_valid,
    // and in_ready as seen the cycle after the result handshake.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] d, output logic bo, output logic ov,
                         output int lat, output logic ir_after);
        int n;
        @(negedge clk);
        A = a;
        B = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("do_op_wait_in_ready", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        d  = D;
        bo = BORROW;
`ifdef SERIAL_SUB_OVF_EN
        ov = ovf;
`else
        ov = 1'b0;
`endif
        @(negedge clk);
        ir_after = in_ready && !out_valid;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        logic             ir;
        int               lat;
        int               n;
        int               k;
        int               got;
        int               cyc;
        int               acc_cyc[3];
        logic [WIDTH-1:0] pa[3];
        logic [WIDTH-1:0] pb[3];
        logic [WIDTH:0]   exp_r;

        // Hand-computed vectors: {A, B, D, BORROW, OVF}
        vecs[0]  = '{4'd7,  4'd3,  4'd4,  1'b0, 1'b0};
        vecs[1]  = '{4'd3,  4'd7,  4'd12, 1'b1, 1'b0};
        vecs[2]  = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b0};
        vecs[3]  = '{4'd0,  4'd1,  4'd15, 1'b1, 1'b0};
        vecs[4]  = '{4'd9,  4'd2,  4'd7,  1'b0, 1'b1};
        vecs[5]  = '{4'd6,  4'd4,  4'd2,  1'b0, 1'b0};
        vecs[6]  = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b1};
        vecs[7]  = '{4'd7,  4'd15, 4'd8,  1'b1, 1'b1};
        vecs[8]  = '{4'd5,  4'd3,  4'd2,  1'b0, 1'b0};
        vecs[9]  = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
        vecs[10] = '{4'd10, 4'd5,  4'd5,  1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_d", D, 0);
        check("reset_borrow", BORROW, 0);
        check("reset_busy", busy, 0);
        check("reset_state", state_dbg, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        rst = 1'b0;

        // Table-driven single operations
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, d, bo, ov, lat, ir);
            check($sformatf("vec%0d_latency", i), lat, WIDTH);
            check($sformatf("vec%0d_d", i), d, vecs[i].exp_d);
            check($sformatf("vec%0d_borrow", i), bo, vecs[i].exp_borrow);
            // in_ready returns the cycle after the handshake, so the next
            // accept can land two edges after out_valid rose.
            check($sformatf("vec%0d_in_ready_after", i), ir, 1);
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ovf);
`endif
        end

        // Backpressure with ignored in_valid pulses
        @(negedge clk);
        A = 4'd9;
        B = 4'd2;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        A = 4'd1;
        B = 4'd1;
        check("bp_busy_run", busy, 1);
        check("bp_run_in_ready", in_ready, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_hold%0d_valid", i), out_valid, 1);
            check($sformatf("bp_hold%0d_d", i), D, 7);
            check($sformatf("bp_hold%0d_borrow", i), BORROW, 0);
            check($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_d_kept", D, 7);
        @(negedge clk);
        check("bp_no_queued_op", busy, 0);

        // Reset abort mid-operation; BORROW is 1 beforehand so its clear shows
        do_op(4'd0, 4'd1, d, bo, ov, lat, ir);
        check("pre_abort_borrow", bo, 1);
        @(negedge clk);
        A = 4'd5;
        B = 4'd1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", state_dbg, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_d", D, 0);
        check("abort_borrow", BORROW, 0);
        check("abort_busy", busy, 0);
        do_op(4'd6, 4'd4, d, bo, ov, lat, ir);
        check("post_abort_d", d, 2);
        check("post_abort_latency", lat, WIDTH);

        // Back-to-back: in_valid and out_ready held high, results in order
        pa[0] = 4'd12; pb[0] = 4'd5;
        pa[1] = 4'd2;  pb[1] = 4'd9;
        pa[2] = 4'd14; pb[2] = 4'd14;
        k   = 0;
        got = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (got < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_result", 1, 0);
                end else begin
                    exp_r = exp_q.pop_front();
                    check($sformatf("b2b%0d_d", got), D, exp_r[WIDTH-1:0]);
                    check($sformatf("b2b%0d_borrow", got), BORROW, exp_r[WIDTH]);
                end
                got++;
            end
            if (in_ready) begin
                if (k < 3) begin
                    A = pa[k];
                    B = pb[k];
                    in_valid = 1'b1;
                    acc_cyc[k] = cyc;
                    case (k)
                        0: exp_q.push_back({1'b0, 4'd7});
                        1: exp_q.push_back({1'b1, 4'd9});
                        default: exp_q.push_back({1'b0, 4'd0});
                    endcase
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_results", got, 3);
        check("b2b_accepts", k, 3);
        check("b2b_interval01", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
        check("b2b_interval12", acc_cyc[2] - acc_cyc[1], WIDTH + 2);
        repeat (2) @(negedge clk);
        check("b2b_idle_after", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
